apb_timer: RTL and testbench

- 32-bit APB down-counting timer with prescaler and interrupt.
- Sits directly downstream of axi2apb_bridge and consumes its APB master signals (reg_psel, reg_enable, reg_rw, reg_addr, reg_datai).
- Returns reg_datao and reg_ready_1 to the bridge.
- Gives the CPU a periodic or one-shot interrupt source on the APB segment.

---
 rtl/apb_timer_pkg.sv | 21 ++
 rtl/apb_timer_prescale.sv | 27 ++
 rtl/apb_timer.sv | 119 +++++++++++
 tb/tb_apb_timer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/apb_timer_pkg.sv
// Shared constants for the APB down-counting timer: register map, CTRL bits and defaults.
package apb_timer_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W     = 32;
   localparam int PRE_W_DEF  = 16;

   // Word index of each register, i.e. reg_addr[4:2]
   typedef enum logic [2:0] {
      TMR_CTRL     = 3'd0,
      TMR_LOAD     = 3'd1,
      TMR_COUNT    = 3'd2,
      TMR_STATUS   = 3'd3,
      TMR_PRESCALE = 3'd4
   } tmr_reg_e;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_RELOAD = 1;
   localparam int CTRL_IEN    = 2;

endpackage

// File: rtl/apb_timer_prescale.sv
// Prescaler: free-running pcnt while enabled, one-cycle tick when pcnt matches the prescale value.
module apb_timer_prescale #(
   parameter int PRE_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [PRE_W-1:0] i_prescale,
   output logic             o_tick
);

   logic [PRE_W-1:0] r_pcnt;

   assign o_tick = i_en & (r_pcnt == i_prescale);

   // Only an exact match returns pcnt to 0, so a prescale lowered below pcnt wraps through 2^PRE_W-1
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_pcnt <= '0;
      else if (!i_en || i_clr || o_tick)
         r_pcnt <= '0;
      else
         r_pcnt <= r_pcnt + 1'b1;
   end

endmodule

// File: rtl/apb_timer.sv
// 32-bit APB down-counting timer with prescaler, auto-reload / one-shot modes and level interrupt.
module apb_timer
   import apb_timer_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int PRE_W  = PRE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_psel,
   input  logic              reg_enable,
   input  logic              reg_rw,
   input  logic [ADDR_W-1:0] reg_addr,
   input  logic [DATA_W-1:0] reg_datai,
   output logic [DATA_W-1:0] reg_datao,
   output logic              reg_ready_1,
   output logic              timer_irq
);

   logic [2:0]        r_ctrl;
   logic [DATA_W-1:0] r_load;
   logic [DATA_W-1:0] r_count;
   logic              r_exp;
   logic [PRE_W-1:0]  r_prescale;

   logic [2:0]        w_idx;
   logic              w_wr, w_setup_rd;
   logic              w_wr_ctrl, w_wr_load, w_wr_count, w_wr_status, w_wr_pre;
   logic              w_tick, w_expire, w_pclr;
   logic [DATA_W-1:0] w_rdata;
   logic              w_unused;

   assign w_idx       = reg_addr[4:2];
   assign w_wr        = reg_psel & reg_enable & reg_rw;
   assign w_setup_rd  = reg_psel & ~reg_enable & ~reg_rw;
   assign w_wr_ctrl   = w_wr & (w_idx == TMR_CTRL);
   assign w_wr_load   = w_wr & (w_idx == TMR_LOAD);
   assign w_wr_count  = w_wr & (w_idx == TMR_COUNT);
   assign w_wr_status = w_wr & (w_idx == TMR_STATUS);
   assign w_wr_pre    = w_wr & (w_idx == TMR_PRESCALE);
   assign w_unused    = ^{reg_addr[ADDR_W-1:5], reg_addr[1:0]};

   assign reg_ready_1 = reg_psel & reg_enable & ~rst;
   assign timer_irq   = r_exp & r_ctrl[CTRL_IEN];

   // A software COUNT write on a tick cycle suppresses both the decrement and the expiry
   assign w_expire = w_tick & (r_count == '0) & ~w_wr_count;
   assign w_pclr   = w_wr_ctrl & reg_datai[CTRL_EN] & ~r_ctrl[CTRL_EN];

   apb_timer_prescale #(.PRE_W(PRE_W)) u_pre (
      .clk        (clk),
      .rst        (rst),
      .i_en       (r_ctrl[CTRL_EN]),
      .i_clr      (w_pclr),
      .i_prescale (r_prescale),
      .o_tick     (w_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ctrl     <= '0;
         r_load     <= '0;
         r_prescale <= '0;
      end else begin
         if (w_wr_ctrl)
            r_ctrl <= reg_datai[2:0];
         else if (w_expire && !r_ctrl[CTRL_RELOAD])
            r_ctrl[CTRL_EN] <= 1'b0;
         if (w_wr_load)
            r_load <= reg_datai;
         if (w_wr_pre)
            r_prescale <= reg_datai[PRE_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_count <= '0;
      else if (w_wr_count)
         r_count <= reg_datai;
      else if (w_tick) begin
         if (r_count != '0)
            r_count <= r_count - 1'b1;
         else if (r_ctrl[CTRL_RELOAD])
            r_count <= r_load;
      end
   end

   // Expiry beats a simultaneous W1C
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_exp <= 1'b0;
      else if (w_expire)
         r_exp <= 1'b1;
      else if (w_wr_status && reg_datai[0])
         r_exp <= 1'b0;
   end

   always_comb begin
      w_rdata = '0;
      case (w_idx)
         TMR_CTRL:     w_rdata = {{(DATA_W-3){1'b0}}, r_ctrl};
         TMR_LOAD:     w_rdata = r_load;
         TMR_COUNT:    w_rdata = r_count;
         TMR_STATUS:   w_rdata = {{(DATA_W-1){1'b0}}, r_exp};
         TMR_PRESCALE: w_rdata = {{(DATA_W-PRE_W){1'b0}}, r_prescale};
         default:      w_rdata = '0;
      endcase
   end

   // Read data is captured in the setup phase and held through the access phase
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         reg_datao <= '0;
      else if (w_setup_rd)
         reg_datao <= w_rdata;
   end

endmodule

// File: tb/tb_apb_timer.sv
// Directed bench for apb_timer: reads queue their expected data, a negedge monitor checks them.
module tb_apb_timer;

   logic        clk, rst;
   logic        reg_psel, reg_enable, reg_rw;
   logic [31:0] reg_addr, reg_datai, reg_datao;
   logic        reg_ready_1, timer_irq;

   int total = 0;
   int bad   = 0;
   int rd_id = 0;

   typedef struct {
      logic [31:0] d;
      logic [31:0] a;
      int          id;
   } exp_t;
   exp_t sb[$];

   apb_timer #(.ADDR_W(32), .PRE_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .reg_psel    (reg_psel),
      .reg_enable  (reg_enable),
      .reg_rw      (reg_rw),
      .reg_addr    (reg_addr),
      .reg_datai   (reg_datai),
      .reg_datao   (reg_datao),
      .reg_ready_1 (reg_ready_1),
      .timer_irq   (timer_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   // Monitor: ready must follow the access phase, and every read is checked against the scoreboard
   always @(negedge clk) begin
      if (reg_psel) begin
         total++;
         if (reg_ready_1 !== reg_enable) begin
            bad++;
            $display("FAIL ready_phase addr=%h got=%b exp=%b", reg_addr, reg_ready_1, reg_enable);
         end
      end
      if (reg_psel && reg_enable && !reg_rw) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL rd_unexpected addr=%h got=%h", reg_addr, reg_datao);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (reg_datao !== e.d || reg_addr !== e.a) begin
               bad++;
               $display("FAIL rd%0d addr=%h got=%h exp=%h", e.id, e.a, reg_datao, e.d);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // Called one time unit after a rising edge; returns one time unit after the edge ending the access
   task automatic apb(input logic rw, input logic [31:0] a, input logic [31:0] d);
      reg_psel   = 1'b1;
      reg_enable = 1'b0;
      reg_rw     = rw;
      reg_addr   = a;
      reg_datai  = d;
      @(posedge clk); #1;
      reg_enable = 1'b1;
      @(posedge clk); #1;
      reg_psel   = 1'b0;
      reg_enable = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      apb(1'b1, a, d);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp);
      exp_t e;
      e.d = exp;
      e.a = a;
      e.id = rd_id++;
      sb.push_back(e);
      apb(1'b0, a, 32'h0);
   endtask

   initial begin
      rst = 1'b1; reg_psel = 1'b0; reg_enable = 1'b0; reg_rw = 1'b0;
      reg_addr = '0; reg_datai = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_irq",   timer_irq,   0);
      chk("rst_datao", reg_datao,   0);
      chk("rst_ready", reg_ready_1, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      rd(32'h00, 0); rd(32'h04, 0); rd(32'h08, 0); rd(32'h0C, 0); rd(32'h10, 0);

      // Auto-reload, LOAD=5, PRESCALE=0: expiry every 6 cycles
      wr(32'h04, 5); wr(32'h08, 5); wr(32'h10, 0); wr(32'h00, 7);
      rd(32'h08, 5); rd(32'h08, 3); rd(32'h08, 1); rd(32'h0C, 1);
      chk("irq_rise", timer_irq, 1);
      rd(32'h08, 3);
      wr(32'h0C, 1);                 // commits on the next expiry edge
      rd(32'h0C, 1);
      wr(32'h0C, 1);                 // commits away from expiry
      chk("irq_w1c", timer_irq, 0);
      rd(32'h0C, 0);
      rd(32'h0C, 1);                 // expiry exactly 6 cycles later
      wr(32'h00, 0); wr(32'h0C, 1);

      // One-shot, PRESCALE=3, COUNT=2: expiry 12 cycles after enable
      wr(32'h10, 3); wr(32'h04, 2); wr(32'h08, 2); wr(32'h00, 5);
      rd(32'h08, 2); rd(32'h08, 2); rd(32'h08, 1); rd(32'h08, 1); rd(32'h08, 0);
      rd(32'h0C, 0); rd(32'h0C, 1); rd(32'h00, 4);
      repeat (10) @(posedge clk);
      #1;
      rd(32'h08, 0); rd(32'h0C, 1);
      chk("irq_oneshot", timer_irq, 1);

      // COUNT write on a tick edge, then the unmapped slot
      wr(32'h0C, 1); wr(32'h10, 3); wr(32'h04, 32'h50); wr(32'h08, 32'h50); wr(32'h00, 3);
      rd(32'h08, 32'h50); rd(32'h08, 32'h50); rd(32'h08, 32'h4F);
      wr(32'h08, 32'h100);
      rd(32'h08, 32'h100); rd(32'h08, 32'h100); rd(32'h08, 32'hFF);
      wr(32'h18, 32'hFFFF_FFFF);
      rd(32'h18, 0); rd(32'h00, 3); rd(32'h04, 32'h50); rd(32'h10, 3); rd(32'h0C, 0);
      rd(32'h08, 32'hFC);
      chk("irq_noien", timer_irq, 0);

      // Asynchronous reset mid-count with the interrupt asserted
      wr(32'h00, 0); wr(32'h10, 0); wr(32'h04, 3); wr(32'h08, 0); wr(32'h00, 7);
      rd(32'h04, 3);
      chk("pre_rst_irq",   timer_irq, 1);
      chk("pre_rst_datao", reg_datao, 3);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      chk("async_irq",   timer_irq, 0);
      chk("async_datao", reg_datao, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      rd(32'h00, 0); rd(32'h04, 0); rd(32'h08, 0); rd(32'h0C, 0); rd(32'h10, 0);
      chk("post_rst_irq", timer_irq, 0);

      @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
